// File: rtl/vend_pkg.sv
// Shared encodings for the vending controller: coin codes, coin value lookup, FSM states.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;
  localparam logic [1:0] COIN_FIVE = 2'b11;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_VEND    = 2'd1,
    S_CHANGE  = 2'd2
  } state_t;

  // Coin encoding to credit units (1 unit = 0.5 yuan).
  function automatic logic [3:0] coin_units(input logic [1:0] c);
    case (c)
      COIN_HALF: coin_units = 4'd1;
      COIN_ONE:  coin_units = 4'd2;
      COIN_FIVE: coin_units = 4'd10;
      default:   coin_units = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_disp.sv
// Greedy change payout over a ready/valid handshake; one coin in flight at a time.
module vend_change_disp
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [CREDIT_W-1:0] i_credit,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [1:0]          o_coin,
  output logic [CREDIT_W-1:0] o_dec,
  output logic                o_done
);

  logic                r_valid;
  logic [1:0]          r_coin;
  logic                w_xfer;
  logic [CREDIT_W-1:0] w_dec;
  logic [CREDIT_W-1:0] w_rem;

  function automatic logic [1:0] greedy(input logic [CREDIT_W-1:0] c);
    greedy = (c >= CREDIT_W'(2)) ? COIN_ONE : COIN_HALF;
  endfunction

  assign w_xfer = r_valid & i_ready;
  assign w_dec  = (r_coin == COIN_ONE) ? CREDIT_W'(2) : CREDIT_W'(1);
  assign w_rem  = i_credit - w_dec;

  // Next coin is chosen from the post-transfer remainder so ready held high yields one coin per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_coin  <= COIN_NONE;
    end else if (!r_valid) begin
      if (i_start) begin
        r_valid <= 1'b1;
        r_coin  <= greedy(i_credit);
      end
    end else if (i_ready) begin
      if (w_rem == '0) begin
        r_valid <= 1'b0;
        r_coin  <= COIN_NONE;
      end else begin
        r_coin  <= greedy(w_rem);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_coin  = r_coin;
  assign o_dec   = w_xfer ? w_dec : '0;
  assign o_done  = w_xfer && (w_rem == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Multi-item vending controller: credit collection, vend, greedy change/refund.
// Define VEND_STOCK_EN to compile in per-item stock counters, restock and the out-of-stock check.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int                            NUM_ITEMS  = 4,
  parameter int                            CREDIT_W   = 6,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICE = {6'd6, 6'd5, 6'd4, 6'd3},
  parameter int                            MAX_CREDIT = 20,
  parameter int                            STOCK_W    = 4,
  parameter int                            STOCK_MAX  = 10,
  localparam int                           IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          i_coin,
  input  logic                i_sel_valid,
  input  logic [IW-1:0]       i_sel_item,
  input  logic                i_cancel,
  input  logic                i_restock,
  input  logic [IW-1:0]       i_restock_item,
  output logic                o_vend,
  output logic [IW-1:0]       o_vend_item,
  output logic                o_sel_error,
  output logic                o_coin_reject,
  output logic                o_chg_valid,
  output logic [1:0]          o_chg_coin,
  input  logic                i_chg_ready,
  output logic [CREDIT_W-1:0] o_credit
);

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [IW-1:0]       r_item, w_item_nxt;
  logic                r_sel_err, w_sel_err_nxt;
  logic                r_coin_rej, w_coin_rej_nxt;
  logic [CREDIT_W-1:0] w_sel_price, w_vend_price, w_chg_dec;
  logic [CREDIT_W:0]   w_coin_sum;
  logic                w_coin_in, w_avail, w_chg_done, w_chg_start;

  assign w_sel_price  = ITEM_PRICE[int'(i_sel_item)*CREDIT_W +: CREDIT_W];
  assign w_vend_price = ITEM_PRICE[int'(r_item)*CREDIT_W +: CREDIT_W];
  assign w_coin_in    = (i_coin != COIN_NONE);
  assign w_coin_sum   = {1'b0, r_credit} + (CREDIT_W+1)'(coin_units(i_coin));
  assign w_chg_start  = (r_state == S_CHANGE);

`ifdef VEND_STOCK_EN
  logic [NUM_ITEMS-1:0][STOCK_W-1:0] r_stock;

  assign w_avail = (r_stock[i_sel_item] != '0);

  // Restock is written last so it overrides a same-item decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_MAX);
    end else begin
      if (r_state == S_VEND) r_stock[r_item] <= r_stock[r_item] - STOCK_W'(1);
      if (i_restock) r_stock[i_restock_item] <= STOCK_W'(STOCK_MAX);
    end
  end
`else
  logic w_unused_restock;
  assign w_unused_restock = ^{i_restock, i_restock_item, STOCK_W'(STOCK_MAX)};
  assign w_avail = 1'b1;
`endif

  vend_change_disp #(.CREDIT_W(CREDIT_W)) u_chg (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_chg_start),
    .i_credit (r_credit),
    .i_ready  (i_chg_ready),
    .o_valid  (o_chg_valid),
    .o_coin   (o_chg_coin),
    .o_dec    (w_chg_dec),
    .o_done   (w_chg_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_COLLECT;
    else     r_state <= w_state_nxt;
  end

  // COLLECT priority: cancel (with credit) > selection > coin; a coin that loses is returned.
  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_item_nxt     = r_item;
    w_sel_err_nxt  = 1'b0;
    w_coin_rej_nxt = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (i_cancel && (r_credit != '0)) begin
          w_state_nxt    = S_CHANGE;
          w_coin_rej_nxt = w_coin_in;
        end else if (i_sel_valid) begin
          w_coin_rej_nxt = w_coin_in;
          if ((r_credit >= w_sel_price) && w_avail) begin
            w_state_nxt = S_VEND;
            w_item_nxt  = i_sel_item;
          end else begin
            w_sel_err_nxt = 1'b1;
          end
        end else if (w_coin_in) begin
          if (w_coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) w_credit_nxt   = w_coin_sum[CREDIT_W-1:0];
          else                                         w_coin_rej_nxt = 1'b1;
        end
      end
      S_VEND: begin
        w_coin_rej_nxt = w_coin_in;
        w_credit_nxt   = r_credit - w_vend_price;
        w_state_nxt    = (w_credit_nxt != '0) ? S_CHANGE : S_COLLECT;
      end
      S_CHANGE: begin
        w_coin_rej_nxt = w_coin_in;
        w_credit_nxt   = r_credit - w_chg_dec;
        if (w_chg_done) w_state_nxt = S_COLLECT;
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit   <= '0;
      r_item     <= '0;
      r_sel_err  <= 1'b0;
      r_coin_rej <= 1'b0;
    end else begin
      r_credit   <= w_credit_nxt;
      r_item     <= w_item_nxt;
      r_sel_err  <= w_sel_err_nxt;
      r_coin_rej <= w_coin_rej_nxt;
    end
  end

  assign o_vend        = (r_state == S_VEND);
  assign o_vend_item   = o_vend ? r_item : '0;
  assign o_sel_error   = r_sel_err;
  assign o_coin_reject = r_coin_rej;
  assign o_credit      = r_credit;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: stimulus queues expected output events, a monitor pops and compares.
module tb_vend_ctrl;
  import vend_pkg::*;

  localparam int EV_VEND = 0, EV_SERR = 1, EV_CREJ = 2, EV_CHG = 3;

  logic       clk = 1'b0, rst = 1'b1;
  logic [1:0] i_coin = 2'b00;
  logic       i_sel_valid = 1'b0, i_cancel = 1'b0, i_restock = 1'b0, i_chg_ready = 1'b1;
  logic [1:0] i_sel_item = 2'd0, i_restock_item = 2'd0;
  logic       o_vend, o_sel_error, o_coin_reject, o_chg_valid;
  logic [1:0] o_vend_item, o_chg_coin;
  logic [5:0] o_credit;

  typedef struct { int kind; int data; } ev_t;
  ev_t exp_q[$];
  int  checks = 0, failures = 0;

  vend_ctrl dut (
    .clk(clk), .rst(rst), .i_coin(i_coin), .i_sel_valid(i_sel_valid), .i_sel_item(i_sel_item),
    .i_cancel(i_cancel), .i_restock(i_restock), .i_restock_item(i_restock_item),
    .o_vend(o_vend), .o_vend_item(o_vend_item), .o_sel_error(o_sel_error),
    .o_coin_reject(o_coin_reject), .o_chg_valid(o_chg_valid), .o_chg_coin(o_chg_coin),
    .i_chg_ready(i_chg_ready), .o_credit(o_credit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int data);
    exp_q.push_back('{kind, data});
  endtask

  task automatic pop_ev(input int kind, input int data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d data=%0d expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data != data) begin
        failures++;
        $display("FAIL event: got kind=%0d data=%0d expected kind=%0d data=%0d",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_vend)                     pop_ev(EV_VEND, int'(o_vend_item));
      if (o_sel_error)                pop_ev(EV_SERR, 0);
      if (o_coin_reject)              pop_ev(EV_CREJ, 0);
      if (o_chg_valid && i_chg_ready) pop_ev(EV_CHG, int'(o_chg_coin));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) cyc();
  endtask

  task automatic put_coin(input logic [1:0] c);
    i_coin = c;
    cyc();
    i_coin = 2'b00;
  endtask

  task automatic select(input logic [1:0] item);
    i_sel_valid = 1'b1;
    i_sel_item  = item;
    cyc();
    i_sel_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    drain(2);
    check("rst_credit", o_credit, 0);
    check("rst_vend", o_vend, 0);
    check("rst_chg_valid", o_chg_valid, 0);
    check("rst_errs", {o_sel_error, o_coin_reject}, 0);
    rst = 1'b0;
    cyc();

    // Exact credit, no change
    put_coin(2'b01);
    check("t1_credit1", o_credit, 1);
    put_coin(2'b10);
    check("t1_credit3", o_credit, 3);
    push(EV_VEND, 0);
    select(2'd0);
    check("t1_vend_high", o_vend, 1);
    cyc();
    check("t1_credit0", o_credit, 0);
    check("t1_no_chg", o_chg_valid, 0);
    cyc();
    check("t1_no_chg2", o_chg_valid, 0);

    // 5 yuan, item1 costs 4 units, change 3x 1 yuan
    put_coin(2'b11);
    check("t2_credit10", o_credit, 10);
    push(EV_VEND, 1);
    push(EV_CHG, 2); push(EV_CHG, 2); push(EV_CHG, 2);
    select(2'd1);
    drain(6);
    check("t2_credit0", o_credit, 0);
    check("t2_q_empty", exp_q.size(), 0);

    // Insufficient credit, then cancel refund
    put_coin(2'b10);
    put_coin(2'b01);
    check("t3_credit3", o_credit, 3);
    push(EV_SERR, 0);
    select(2'd3);
    check("t3_no_vend", o_vend, 0);
    check("t3_credit_kept", o_credit, 3);
    push(EV_CHG, 2); push(EV_CHG, 1);
    i_cancel = 1'b1;
    cyc();
    i_cancel = 1'b0;
    drain(5);
    check("t3_credit0", o_credit, 0);

    // Credit ceiling
    put_coin(2'b11);
    repeat (4) put_coin(2'b10);
    check("t4_credit18", o_credit, 18);
    push(EV_CREJ, 0);
    put_coin(2'b11);
    check("t4_credit_after_rej", o_credit, 18);

    // Coin during CHANGE, stalled handshake, reset mid-payout
    i_chg_ready = 1'b0;
    i_cancel = 1'b1;
    cyc();
    i_cancel = 1'b0;
    push(EV_CREJ, 0);
    put_coin(2'b01);
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_valid", o_chg_valid, 1);
      check("t4_stall_coin", o_chg_coin, 2);
      check("t4_stall_credit", o_credit, 18);
      cyc();
    end
    push(EV_CHG, 2); push(EV_CHG, 2);
    i_chg_ready = 1'b1;
    cyc();
    cyc();
    i_chg_ready = 1'b0;
    check("t4_credit14", o_credit, 14);
    check("t4_still_valid", o_chg_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t4_rst_valid", o_chg_valid, 0);
    check("t4_rst_credit", o_credit, 0);
    cyc();
    rst = 1'b0;
    i_chg_ready = 1'b1;
    cyc();
    check("t4_q_empty", exp_q.size(), 0);

    // Stock depletion on item2 (price 5)
    for (int k = 0; k < 11; k++) begin
      put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
`ifdef VEND_STOCK_EN
      if (k < 10) push(EV_VEND, 2);
      else        push(EV_SERR, 0);
`else
      push(EV_VEND, 2);
`endif
      select(2'd2);
      cyc();
    end
`ifdef VEND_STOCK_EN
    check("t5_credit_kept", o_credit, 5);
`else
    check("t5_credit0", o_credit, 0);
    put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
`endif
    i_restock = 1'b1;
    i_restock_item = 2'd2;
    cyc();
    i_restock = 1'b0;
    push(EV_VEND, 2);
    select(2'd2);
    cyc();
    check("t5_credit_final", o_credit, 0);

    drain(3);
    check("final_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
